// File: rtl/ms_bcd_counter.sv
// Millisecond stopwatch: DIGITS-digit BCD counter with start/stop/clear FSM.
// Optional lap freeze of the displayed count is built when LAP_HOLD_EN is defined.

module ms_bcd_digit (
  input  logic       CLK,
  input  logic       RST,
  input  logic       clr,
  input  logic       inc,
  input  logic       hold,
  output logic [3:0] q,
  output logic       cout
);
  // Carry is independent of hold so the top can see the overflow before deciding to saturate
  assign cout = inc & (q == 4'd9);

  always_ff @(posedge CLK or posedge RST)
    if (RST)              q <= '0;
    else if (clr)         q <= '0;
    else if (inc & ~hold) q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
endmodule

module ms_bcd_counter #(
  parameter int DIGITS = 4,
  parameter int WRAP   = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                TICK,
  input  logic                BTN_SS,
  input  logic                BTN_CLR,
`ifdef LAP_HOLD_EN
  input  logic                LAP,
`endif
  output logic [4*DIGITS-1:0] BCD,
  output logic                RUNNING,
  output logic                OVF
);
  typedef enum logic [1:0] {IDLE, RUN, STOP, SAT} state_t;

  state_t                  state, nxt;
  logic                    ss_d, ss_edge;
  logic                    cnt_en, sat_hit;
  logic [DIGITS:0]         cy;
  logic [DIGITS-1:0][3:0]  cnt;

  assign ss_edge = BTN_SS & ~ss_d;
  assign cnt_en  = TICK & (state == RUN) & ~BTN_CLR;
  assign cy[0]   = cnt_en;
  // cy[DIGITS] fires exactly when a counted tick meets all-nines
  assign sat_hit = cy[DIGITS] & (WRAP == 0);

  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_dig
      ms_bcd_digit u_dig (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (BTN_CLR),
        .inc  (cy[i]),
        .hold (sat_hit),
        .q    (cnt[i]),
        .cout (cy[i+1])
      );
    end
  endgenerate

  // Delay register resets high so a button held through reset is not an edge
  always_ff @(posedge CLK or posedge RST)
    if (RST) ss_d <= 1'b1;
    else     ss_d <= BTN_SS;

  always_comb begin
    nxt = state;
    if (BTN_CLR) nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (ss_edge) nxt = RUN;
        RUN:     if (sat_hit) nxt = SAT;
                 else if (ss_edge) nxt = STOP;
        STOP:    if (ss_edge) nxt = RUN;
        SAT:     nxt = SAT;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state   <= IDLE;
      RUNNING <= 1'b0;
      OVF     <= 1'b0;
    end else begin
      state   <= nxt;
      RUNNING <= (nxt == RUN);
      if (BTN_CLR)         OVF <= 1'b0;
      else if (cy[DIGITS]) OVF <= 1'b1;
    end

`ifdef LAP_HOLD_EN
  logic                   lap_d, lap_edge, frz;
  logic [DIGITS-1:0][3:0] hold_q;

  assign lap_edge = LAP & ~lap_d;

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      lap_d  <= 1'b1;
      frz    <= 1'b0;
      hold_q <= '0;
    end else begin
      lap_d <= LAP;
      if (BTN_CLR) frz <= 1'b0;
      else if (frz) begin
        if (lap_edge || (state == RUN && (nxt == STOP || nxt == SAT))) frz <= 1'b0;
      end else if (lap_edge && state == RUN) begin
        frz    <= 1'b1;
        hold_q <= cnt;
      end
    end

  assign BCD = frz ? hold_q : cnt;
`else
  assign BCD = cnt;
`endif
endmodule

// File: tb/tb_ms_bcd_counter.sv
// Bench for ms_bcd_counter: WRAP=0 and WRAP=1 instances driven in lockstep.
// Lap-freeze sequence is exercised when LAP_HOLD_EN is defined.

module tb_ms_bcd_counter;
  logic CLK = 1'b0;
  logic RST, TICK, BTN_SS, BTN_CLR;
`ifdef LAP_HOLD_EN
  logic LAP;
`endif
  logic [15:0] bcd0, bcd1;
  logic        run0, run1, ovf0, ovf1;

  always #5 CLK = ~CLK;

  ms_bcd_counter #(.DIGITS(4), .WRAP(0)) u0 (
    .CLK(CLK), .RST(RST), .TICK(TICK), .BTN_SS(BTN_SS), .BTN_CLR(BTN_CLR),
`ifdef LAP_HOLD_EN
    .LAP(LAP),
`endif
    .BCD(bcd0), .RUNNING(run0), .OVF(ovf0));

  ms_bcd_counter #(.DIGITS(4), .WRAP(1)) u1 (
    .CLK(CLK), .RST(RST), .TICK(TICK), .BTN_SS(BTN_SS), .BTN_CLR(BTN_CLR),
`ifdef LAP_HOLD_EN
    .LAP(LAP),
`endif
    .BCD(bcd1), .RUNNING(run1), .OVF(ovf1));

  typedef struct {
    logic [15:0] b0; logic r0, o0;
    logic [15:0] b1; logic r1, o1;
  } exp_t;

  typedef struct {
    logic t, s, c;
    exp_t e;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[8];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic exp_t mk(logic [15:0] b0, logic r0, logic o0,
                              logic [15:0] b1, logic r1, logic o1);
    exp_t x;
    x.b0 = b0; x.r0 = r0; x.o0 = o0;
    x.b1 = b1; x.r1 = r1; x.o1 = o1;
    return x;
  endfunction

  function automatic exp_t mk2(logic [15:0] b, logic r, logic o);
    return mk(b, r, o, b, r, o);
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic bad_digit(logic [15:0] v);
    logic b = 1'b0;
    for (int k = 0; k < 4; k++) if (v[4*k +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, req);
    end
  endtask

  task automatic cmp_all(exp_t x);
    chk("bcd0", bcd0, x.b0);
    chk("run0", {15'd0, run0}, {15'd0, x.r0});
    chk("ovf0", {15'd0, ovf0}, {15'd0, x.o0});
    chk("bcd1", bcd1, x.b1);
    chk("run1", {15'd0, run1}, {15'd0, x.r1});
    chk("ovf1", {15'd0, ovf1}, {15'd0, x.o1});
    chk("digit0", {15'd0, bad_digit(bcd0)}, 16'd0);
    chk("digit1", {15'd0, bad_digit(bcd1)}, 16'd0);
  endtask

  task automatic step(input logic t, input logic s, input logic c, input exp_t e);
    exp_t x;
    @(negedge CLK);
    TICK = t; BTN_SS = s; BTN_CLR = c;
    sbq.push_back(e);
    @(posedge CLK);
    #1;
    x = sbq.pop_front();
    cmp_all(x);
  endtask

  initial begin
    // post-9999 phase: saturate vs wrap, SAT ignores start/stop, clear recovers
    tbl[0] = '{1'b1, 1'b0, 1'b0, mk(16'h9999, 0, 1, 16'h0000, 1, 1)};
    tbl[1] = '{1'b0, 1'b1, 1'b0, mk(16'h9999, 0, 1, 16'h0000, 0, 1)};
    tbl[2] = '{1'b0, 1'b0, 1'b0, mk(16'h9999, 0, 1, 16'h0000, 0, 1)};
    tbl[3] = '{1'b1, 1'b0, 1'b0, mk(16'h9999, 0, 1, 16'h0000, 0, 1)};
    tbl[4] = '{1'b0, 1'b1, 1'b0, mk(16'h9999, 0, 1, 16'h0000, 1, 1)};
    tbl[5] = '{1'b1, 1'b0, 1'b0, mk(16'h9999, 0, 1, 16'h0001, 1, 1)};
    tbl[6] = '{1'b1, 1'b1, 1'b1, mk2(16'h0000, 0, 0)};
    tbl[7] = '{1'b1, 1'b0, 1'b0, mk2(16'h0000, 0, 0)};

    RST = 1'b1; TICK = 1'b0; BTN_SS = 1'b1; BTN_CLR = 1'b0;
`ifdef LAP_HOLD_EN
    LAP = 1'b0;
`endif
    #12;
    cmp_all(mk2(16'h0000, 0, 0));
    @(negedge CLK);
    RST = 1'b0;

    // button held through reset release: no start
    step(0, 1, 0, mk2(16'h0000, 0, 0));
    step(0, 1, 0, mk2(16'h0000, 0, 0));
    step(0, 0, 0, mk2(16'h0000, 0, 0));

    // start, 1234 ticks, stop
    step(0, 1, 0, mk2(16'h0000, 1, 0));
    step(0, 0, 0, mk2(16'h0000, 1, 0));
    for (int i = 1; i <= 1234; i++) step(1, 0, 0, mk2(to_bcd(i), 1, 0));
    step(0, 1, 0, mk2(16'h1234, 0, 0));
    step(0, 0, 0, mk2(16'h1234, 0, 0));
    step(1, 0, 0, mk2(16'h1234, 0, 0));

    // clear, start with coincident tick (no count), carry 0099 -> 0100
    step(0, 0, 1, mk2(16'h0000, 0, 0));
    step(1, 1, 0, mk2(16'h0000, 1, 0));
    for (int i = 1; i <= 99; i++) step(1, 0, 0, mk2(to_bcd(i), 1, 0));
    step(1, 0, 0, mk2(16'h0100, 1, 0));
    for (int i = 101; i <= 500; i++) step(1, 0, 0, mk2(to_bcd(i), 1, 0));

    // stop with coincident tick counts; clear overrides tick
    step(1, 1, 0, mk2(16'h0501, 0, 0));
    step(1, 0, 0, mk2(16'h0501, 0, 0));
    step(1, 0, 1, mk2(16'h0000, 0, 0));

    // reset mid-count
    step(0, 1, 0, mk2(16'h0000, 1, 0));
    for (int i = 1; i <= 5; i++) step(1, 0, 0, mk2(to_bcd(i), 1, 0));
    @(negedge CLK);
    TICK = 1'b1; BTN_SS = 1'b0; RST = 1'b1;
    #1;
    cmp_all(mk2(16'h0000, 0, 0));
    @(negedge CLK);
    RST = 1'b0;
    step(1, 0, 0, mk2(16'h0000, 0, 0));
    step(0, 1, 0, mk2(16'h0000, 1, 0));
    step(1, 0, 0, mk2(16'h0001, 1, 0));

    // run up to all-nines, then apply the table
    step(0, 0, 1, mk2(16'h0000, 0, 0));
    step(0, 1, 0, mk2(16'h0000, 1, 0));
    for (int i = 1; i <= 9999; i++) step(1, 0, 0, mk2(to_bcd(i), 1, 0));
    for (int i = 0; i < 8; i++) step(tbl[i].t, tbl[i].s, tbl[i].c, tbl[i].e);

`ifdef LAP_HOLD_EN
    // lap freeze at 0042, counting continues underneath, second lap releases
    step(0, 1, 0, mk2(16'h0000, 1, 0));
    for (int i = 1; i <= 42; i++) step(1, 0, 0, mk2(to_bcd(i), 1, 0));
    LAP = 1'b1;
    step(0, 0, 0, mk2(16'h0042, 1, 0));
    LAP = 1'b0;
    for (int i = 1; i <= 10; i++) step(1, 0, 0, mk2(16'h0042, 1, 0));
    LAP = 1'b1;
    step(0, 0, 0, mk2(16'h0052, 1, 0));
    LAP = 1'b0;
    step(1, 0, 0, mk2(16'h0053, 1, 0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ms_bcd_counter.md
MS_BCD_COUNTER -- requirements
Module: ms_bcd_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4: number of BCD digits in the count, legal range 1..8.
REQ-002 The block SHALL have parameter WRAP, default 0: 0 = saturate and halt at all-nines, 1 = roll over to zero and keep counting.
REQ-003 The block SHALL have port CLK  input  1  system clock, all logic rising-edge.
REQ-004 The block SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port TICK  input  1  one-cycle millisecond strobe from the terminal-count comparator.
REQ-006 The block SHALL have port BTN_SS  input  1  start/stop request, synchronous level, acted on at its rising edge.
REQ-007 The block SHALL have port BTN_CLR  input  1  clear request, synchronous level, acted on every cycle it is high.
REQ-008 The block SHALL have port LAP  input  1  lap-freeze request, synchronous level, present only with LAP_HOLD_EN.
REQ-009 The block SHALL have port BCD  output  4*DIGITS  displayed count, digit 0 (units) in bits [3:0].
REQ-010 The block SHALL have port RUNNING  output  1  high while state is RUN.
REQ-011 The block SHALL have port OVF  output  1  sticky flag: the count has passed all-nines.

Function
REQ-012 The block SHALL implement a four-state FSM: IDLE, RUN, STOP, SAT.
REQ-013 The block SHALL detect a BTN_SS edge as BTN_SS high while its one-cycle-delayed copy is low.
REQ-014 On a BTN_SS edge the FSM SHALL go IDLE->RUN, RUN->STOP and STOP->RUN; SAT SHALL ignore BTN_SS.
REQ-015 BTN_CLR high SHALL, on that clock edge, zero the count, clear OVF and force IDLE, overriding TICK, BTN_SS and LAP.
REQ-016 The count SHALL increment by one when TICK is high and the current (pre-edge) state is RUN, with the result visible the next cycle (latency 1).
REQ-017 When TICK and a stopping BTN_SS edge arrive together in RUN, the block SHALL apply the increment and enter STOP.
REQ-018 When TICK and a starting BTN_SS edge arrive together in IDLE or STOP, the block SHALL NOT increment.
REQ-019 Each digit SHALL count 0..9; a digit at 9 with carry-in SHALL go to 0 and carry to the next digit in the same cycle.
REQ-020 No digit SHALL ever hold a value 10..15.
REQ-021 With WRAP=0 and the count at all-nines, a counted TICK SHALL hold the count at all-nines, set OVF and move the FSM to SAT.
REQ-022 SAT SHALL be left only via BTN_CLR or RST.
REQ-023 With WRAP=1 and the count at all-nines, a counted TICK SHALL roll the count to zero, set OVF and remain in RUN.
REQ-024 RUNNING SHALL be a registered decode of state RUN.
REQ-025 BCD SHALL equal the live count whenever no lap freeze is active.

Reset
REQ-026 RST high SHALL immediately clear the count to zero, BCD to zero, OVF to 0 and RUNNING to 0, and put the FSM in IDLE.
REQ-027 RST high SHALL set the BTN_SS delay register to 1, so that a button held through reset release generates no edge.
REQ-028 RST asserted mid-count SHALL discard the count; operation SHALL resume from IDLE on the first edge after release.

Configuration
REQ-029 The block SHALL support the macro LAP_HOLD_EN.
REQ-030 With LAP_HOLD_EN defined, a LAP rising edge in RUN SHALL capture the live count into a hold register.
REQ-031 With LAP_HOLD_EN defined, BCD SHALL show the hold register while the freeze is active, and counting SHALL continue underneath.
REQ-032 With LAP_HOLD_EN defined, a second LAP edge, entry to STOP or SAT, or BTN_CLR SHALL release the freeze.
REQ-033 With LAP_HOLD_EN undefined, the LAP port and hold register SHALL be absent and BCD SHALL always show the live count.

Verification
REQ-034 The bench SHALL cover: reset, BTN_SS edge, 1234 TICKs, BTN_SS edge -> BCD=16'h1234, RUNNING 1 then 0, OVF=0.
REQ-035 The bench SHALL cover: count 0099 in RUN, one TICK -> BCD=16'h0100 one cycle later, with no digit ever showing A-F.
REQ-036 The bench SHALL cover: WRAP=0, count 9999, TICK -> BCD=16'h9999, OVF=1, state SAT; BTN_SS edge -> no change; BTN_CLR -> 0000, IDLE, OVF=0.
REQ-037 The bench SHALL cover: WRAP=1, count 9999, TICK -> BCD=16'h0000, OVF=1, RUNNING stays 1.
REQ-038 The bench SHALL cover: count 0500 in RUN, TICK with BTN_SS edge in the same cycle -> 0501 and STOP; then BTN_CLR with TICK -> 0000, IDLE.
REQ-039 The bench SHALL cover, with LAP_HOLD_EN: LAP edge at 0042, then 10 TICKs -> BCD=16'h0042; second LAP edge -> BCD=16'h0052.
